// File: rtl/nv_nvdla_dmaif_rdreq_route.sv
// nv_nvdla_dmaif_rdreq_route: routes DMA read requests to per-interface skid FIFOs and logs targets in an in-order route FIFO
module nv_nvdla_dmaif_rdreq_route #(
  parameter int AW = 64,
  parameter int NUM_IF = 2,
  parameter int ORD_DEPTH = 8,
  localparam int PW = AW + 15,
  localparam int SELW = NUM_IF > 1 ? $clog2(NUM_IF) : 1,
  localparam int OCW = $clog2(ORD_DEPTH) + 1
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic [PW-1:0]        dmaif_rd_req_pd,
  input  logic [SELW-1:0]      dmaif_rd_req_sel,
  input  logic                 dmaif_rd_req_vld,
  output logic                 dmaif_rd_req_rdy,
  output logic [NUM_IF*PW-1:0] memif_rd_req_pd,
  output logic [NUM_IF-1:0]    memif_rd_req_valid,
  input  logic [NUM_IF-1:0]    memif_rd_req_ready,
  output logic [SELW-1:0]      ord_sel,
  output logic                 ord_vld,
  input  logic                 ord_pop,
  output logic [OCW-1:0]       ord_cnt,
  output logic                 sel_err
);
  localparam int NS = 1 << SELW;
  localparam int OAW = $clog2(ORD_DEPTH);
  logic sel_ok, accept, ord_full, ord_push, ord_pop_ok;
  logic [NUM_IF-1:0] skid_full;
  logic [NS-1:0] full_pad;
  logic [SELW-1:0] ord_mem [ORD_DEPTH];
  logic [OAW-1:0] ord_wp, ord_rp;
  // Zero-padding lets out-of-range selects index safely; they are masked by sel_ok anyway.
  assign sel_ok = {1'b0, dmaif_rd_req_sel} < (SELW + 1)'(NUM_IF);
  assign full_pad = NS'(skid_full);
  assign ord_full = ord_cnt == OCW'(ORD_DEPTH);
  assign dmaif_rd_req_rdy = sel_ok ? !full_pad[dmaif_rd_req_sel] && !ord_full : 1'b1;
  assign accept = dmaif_rd_req_vld & dmaif_rd_req_rdy;
  assign ord_push = accept & sel_ok;
  assign ord_vld = ord_cnt != '0;
  assign ord_pop_ok = ord_pop & ord_vld;
  assign ord_sel = ord_mem[ord_rp];
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      ord_cnt <= '0;
      ord_wp <= '0;
      ord_rp <= '0;
      sel_err <= 1'b0;
    end else begin
      ord_cnt <= ord_cnt + OCW'(ord_push) - OCW'(ord_pop_ok);
      ord_wp <= ord_push ? ord_wp + OAW'(1) : ord_wp;
      ord_rp <= ord_pop_ok ? ord_rp + OAW'(1) : ord_rp;
      sel_err <= accept & !sel_ok;
    end
  always_ff @(posedge nvdla_core_clk)
    if (ord_push) ord_mem[ord_wp] <= dmaif_rd_req_sel;
  for (genvar g = 0; g < NUM_IF; g++) begin : g_skid
    logic [PW-1:0] mem [2];
    logic wp, rp, push, pop;
    logic [1:0] cnt;
    assign push = accept & (dmaif_rd_req_sel == SELW'(g));
    assign pop = memif_rd_req_valid[g] & memif_rd_req_ready[g];
    assign memif_rd_req_valid[g] = cnt != 2'd0;
    assign skid_full[g] = cnt == 2'd2;
    assign memif_rd_req_pd[g*PW +: PW] = mem[rp];
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
      if (!nvdla_core_rstn) begin
        cnt <= 2'd0;
        wp <= 1'b0;
        rp <= 1'b0;
      end else begin
        cnt <= cnt + 2'(push) - 2'(pop);
        wp <= wp ^ push;
        rp <= rp ^ pop;
      end
    always_ff @(posedge nvdla_core_clk)
      if (push) mem[wp] <= dmaif_rd_req_pd;
  end
endmodule
